// File: rtl/xnor_sweep_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : xnor_sweep_ctrl_if
// Description : Handshake and datapath bundle between the lab control logic /
//               XNOR datapath (master side) and the sweep controller (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface xnor_sweep_ctrl_if;
    logic       start;
    logic       abort;
    logic       f;
    logic       A;
    logic       B;
    logic       C;
    logic       busy;
    logic       done;
    logic       pass;
    logic [3:0] err_cnt;

    // Control logic and datapath side: requests sweeps, returns f
    modport master (
        output start, abort, f,
        input  A, B, C, busy, done, pass, err_cnt
    );

    // Sweep controller side: owns the datapath inputs and status
    modport slave (
        input  start, abort, f,
        output A, B, C, busy, done, pass, err_cnt
    );
endinterface
`default_nettype wire

// File: rtl/xnor_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : xnor_sweep_ctrl
// Description : Drives all eight {A,B,C} vectors into the 3-input XNOR
//               datapath, holds each for HOLD_CYCLES cycles, samples f at the
//               end of each hold window against even parity, and reports a
//               mismatch count and pass flag.
//               Optional macro SWEEP_LOOP_EN: repeat sweeps continuously until
//               abort or reset.
// Revision    : 1.0 - initial release
// ============================================================================
module xnor_sweep_ctrl #(
    parameter int HOLD_CYCLES = 4,   // 1..255
    parameter int HOLD_W      = 8    // 2**HOLD_W must exceed HOLD_CYCLES
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    xnor_sweep_ctrl_if.slave   sweep
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_DRIVE = 1'b1
    } state_t;

    localparam logic [HOLD_W-1:0] c_HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [3:0]        c_ERR_MAX   = 4'd8;

    state_t            r_state;
    logic [2:0]        r_vec;
    logic [HOLD_W-1:0] r_hold;
    logic              r_busy;
    logic              r_done;
    logic              r_pass;
    logic [3:0]        r_err;

    logic              w_sample;
    logic              w_expected;
    logic              w_mismatch;
    logic [3:0]        w_err_base;
    logic [3:0]        w_err_next;

`ifdef SWEEP_LOOP_EN
    // Set on the wrap edge so the finished sweep's count is visible for one
    // cycle before it is discarded.
    logic              r_clr;
    assign w_err_base = r_clr ? 4'd0 : r_err;
`else
    assign w_err_base = r_err;
`endif

    assign w_sample   = (r_state == ST_DRIVE) && (r_hold == c_HOLD_LAST);
    assign w_expected = ~(r_vec[2] ^ r_vec[1] ^ r_vec[0]);
    assign w_mismatch = w_sample && (sweep.f != w_expected);
    assign w_err_next = (w_mismatch && (w_err_base != c_ERR_MAX))
                      ? w_err_base + 4'd1 : w_err_base;

    // Sweep sequencer: vector stepping, hold timing, scoring and status flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_vec   <= 3'd0;
            r_hold  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
            r_err   <= 4'd0;
`ifdef SWEEP_LOOP_EN
            r_clr   <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
`ifdef SWEEP_LOOP_EN
            r_clr  <= 1'b0;
`endif
            case (r_state)
                ST_IDLE: begin
                    // abort is meaningless here, so start always wins
                    if (sweep.start) begin
                        r_err   <= 4'd0;
                        r_pass  <= 1'b0;
                        r_vec   <= 3'd0;
                        r_hold  <= '0;
                        r_busy  <= 1'b1;
                        r_state <= ST_DRIVE;
                    end
                end
                ST_DRIVE: begin
                    if (sweep.abort) begin
                        // Partial count is kept for inspection
                        r_state <= ST_IDLE;
                        r_vec   <= 3'd0;
                        r_hold  <= '0;
                        r_busy  <= 1'b0;
                        r_err   <= w_err_base;
                    end else if (w_sample) begin
                        r_hold <= '0;
                        r_err  <= w_err_next;
                        if (r_vec == 3'd7) begin
                            r_done <= 1'b1;
                            r_pass <= (w_err_next == 4'd0);
`ifdef SWEEP_LOOP_EN
                            r_vec  <= 3'd0;
                            r_clr  <= 1'b1;
`else
                            r_busy  <= 1'b0;
                            r_state <= ST_IDLE;
`endif
                        end else begin
                            r_vec <= r_vec + 3'd1;
                        end
                    end else begin
                        r_hold <= r_hold + HOLD_W'(1);
                        r_err  <= w_err_base;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign sweep.A       = r_vec[2];
    assign sweep.B       = r_vec[1];
    assign sweep.C       = r_vec[0];
    assign sweep.busy    = r_busy;
    assign sweep.done    = r_done;
    assign sweep.pass    = r_pass;
    assign sweep.err_cnt = r_err;

endmodule
`default_nettype wire

// File: doc/xnor_sweep_ctrl.md
# xnor_sweep_ctrl

Sequencer that exhaustively exercises the 3-input SOP XNOR datapath in hardware. On `start` it drives all eight `{A,B,C}` combinations in ascending order, holding each for a programmable number of cycles. It samples the datapath output `f` at the end of each hold window and checks it against the expected even-parity value. It then reports a pass flag and a mismatch count. It sits between the lab control logic (push-button start/abort) and the combinational XNOR block, whose `A`, `B`, `C` inputs it owns.

## Interface
- `HOLD_CYCLES`, 4, cycles each vector is held before `f` is sampled; legal range 1..255.
- `HOLD_W`, 8, width of the internal hold counter; must satisfy `2**HOLD_W > HOLD_CYCLES`.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `start`  in  1  request a sweep; sampled only in IDLE.
- `abort`  in  1  cancel a running sweep.
- `f`  in  1  output of the XNOR datapath under test.
- `A`, `B`, `C`  out  1 each  datapath inputs, registered; `{A,B,C}` = current vector index, with A as the MSB.
- `busy`  out  1  high while a sweep is in progress.
- `done`  out  1  one-cycle pulse when a sweep completes normally.
- `pass`  out  1  1 when the last completed sweep had zero mismatches.
- `err_cnt`  out  4  mismatch count of the current or last sweep (0..8).

## Operation
- States: IDLE, DRIVE. No other states; unused encodings return to IDLE.
- Reset values: state=IDLE, `{A,B,C}`=000, hold counter=0, `busy`=0, `done`=0, `pass`=0, `err_cnt`=0.
- IDLE behaviour:
  - `start`=1 clears `err_cnt` and `pass`, sets `{A,B,C}`=000, clears the hold counter, sets `busy`=1, and enters DRIVE.
  - In IDLE, `{A,B,C}` holds its last value.
- DRIVE behaviour:
  - The hold counter increments every cycle.
  - When the counter equals `HOLD_CYCLES-1`, that edge is the sample edge: `f` is compared against expected = ~(A^B^C).
  - On a mismatch, `err_cnt` increments (saturating at 8).
  - The counter is cleared at the sample edge.
- At the sample edge, if vector < 7: `{A,B,C}` increments by 1 and the controller stays in DRIVE.
- At the sample edge, if vector = 7: the controller goes to IDLE with `busy`=0 and `done`=1 for one cycle. `pass` is set to 1 iff the final `err_cnt` (including this sample) is 0.
- Abort: `abort`=1 in DRIVE forces IDLE next edge with `{A,B,C}`=000 and `busy`=0. `done` is not pulsed and `pass` stays 0; `err_cnt` keeps its partial value.
  - `abort` has priority over the sample-edge transition in the same cycle.
  - `abort` in IDLE has no effect.
- `start` while in DRIVE is ignored.
- `start` and `abort` high together in IDLE: the sweep starts (abort is ignored in IDLE).
- `pass` and `err_cnt` hold their values until the next accepted `start` or reset.
- Asserting `rst_n` low mid-sweep returns all outputs to their reset values immediately, without waiting for a clock edge.

## Timing
- If `start` is accepted at edge k, then `busy`=1 and `{A,B,C}`=000 from edge k onward.
- Vector i is driven from edge k+i·H to edge k+(i+1)·H, where H=`HOLD_CYCLES`.
- `f` for vector i is sampled at edge k+(i+1)·H.
- `done` is high for the single cycle after edge k+8·H.
- `busy` falls at edge k+8·H.
- A full sweep takes 8·H cycles.
- With H=1, every edge in DRIVE is a sample edge and the sweep takes 8 cycles.
- The earliest new `start` is accepted at edge k+8·H+1.
- `f` is assumed combinational from `{A,B,C}` and settles within one cycle; H≥2 gives margin for slower paths.

## Configuration
- `SWEEP_LOOP_EN`, when defined, makes the controller repeat sweeps continuously:
  - After vector 7, it wraps to 000 and stays in DRIVE.
  - It pulses `done` and updates `pass` at each wrap.
  - `err_cnt` is cleared on the cycle after the wrap.
  - Only `abort` or reset returns it to IDLE.
- When not defined, a sweep is single-shot as described above.

## Test plan
- Correct datapath (`f` = ~(A^B^C)), H=4, pulse `start` → `{A,B,C}` steps 000..111 every 4 cycles, `done` pulses 32 cycles after start, `pass`=1, `err_cnt`=0.
- `f` stuck at 0, H=4 → `err_cnt`=4 (vectors 000, 011, 101, 110), `pass`=0, `done` pulses once.
- `f` inverted (~expected), H=1 → sweep takes 8 cycles, `err_cnt`=8 (saturation boundary), `pass`=0.
- `abort` asserted during vector 011 → IDLE on the next edge, `{A,B,C}`=000, `busy`=0, no `done` pulse, `pass`=0. A new `start` then runs a full clean sweep.
- `start` re-pulsed during DRIVE, then `rst_n` pulled low at vector 101 → the re-pulse has no effect. Reset drives `busy`, `A`, `B`, `C`, `err_cnt` and `pass` to 0 asynchronously.
- With `SWEEP_LOOP_EN`, H=2, correct `f` → `done` pulses every 16 cycles, and `{A,B,C}` wraps 111→000 without passing through IDLE.
